// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter sequencer and instruction-fetch handshake.
//
// Chooses the next PC by priority (trap, mret, jump, stall, +4). The fetch
// request is held stable until memory grants it. Every accepted redirect
// produces a registered one-cycle flush.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   stall_i                  pipeline stall (ignored in BOOT and WAIT)
//   jump_en / jump_addr      taken branch/jump and its target
//   trap_en / trap_vec       exception/interrupt and handler address
//   mret_en / mepc           trap return and return address
//   if_gnt                   instruction memory accepts the request
//   if_req / if_addr         fetch request and address (if_addr == curr_pc)
//   curr_pc                  registered PC
//   next_pc                  combinational PC selected for the next update
//   pc_ena                   core enable, set once BOOT completes
//   flush                    one-cycle pulse after an accepted redirect
//   epc_o                    PC captured when a trap is accepted
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | post-reset delay, no fetch, redirects and stall ignored
// ST_RUN  | normal fetch; if_req = !stall_i, redirects apply at once
// ST_WAIT | request outstanding, PC frozen, redirects go to pending reg

module pc_ctrl #(
    parameter int                   CPU_WIDTH  = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC   = '0,
    parameter int                   BOOT_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 jump_en,
    input  logic [CPU_WIDTH-1:0] jump_addr,
    input  logic                 trap_en,
    input  logic [CPU_WIDTH-1:0] trap_vec,
    input  logic                 mret_en,
    input  logic [CPU_WIDTH-1:0] mepc,
    input  logic                 if_gnt,
    output logic                 if_req,
    output logic [CPU_WIDTH-1:0] if_addr,
    output logic [CPU_WIDTH-1:0] curr_pc,
    output logic [CPU_WIDTH-1:0] next_pc,
    output logic                 pc_ena,
    output logic                 flush,
    output logic [CPU_WIDTH-1:0] epc_o
);

    localparam int BOOT_EFF = (BOOT_DELAY < 1) ? 1 : BOOT_DELAY;
    localparam int CNT_W    = $clog2(BOOT_EFF + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_EFF - 1);
    localparam logic [CPU_WIDTH-1:0] ALIGN_MASK = {{(CPU_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [CPU_WIDTH-1:0] PC_STEP    = CPU_WIDTH'(4);

    // Redirect priority codes; larger value wins, 0 means no redirect.
    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_JUMP = 2'd1;
    localparam logic [1:0] PRIO_MRET = 2'd2;
    localparam logic [1:0] PRIO_TRAP = 2'd3;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CPU_WIDTH-1:0] curr_pc_q, curr_pc_d;
    logic                 pc_ena_q, pc_ena_d;
    logic                 flush_q, flush_d;
    logic [CPU_WIDTH-1:0] epc_q, epc_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [1:0]           pend_prio_q, pend_prio_d;
    logic [CPU_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    logic [1:0]           new_prio;
    logic [CPU_WIDTH-1:0] new_tgt;
    logic [CPU_WIDTH-1:0] pc_inc;
    logic                 take_new;

    // Current-cycle redirect request, already word-aligned.
    always_comb begin
        new_prio = PRIO_NONE;
        new_tgt  = '0;
        if (trap_en) begin
            new_prio = PRIO_TRAP;
            new_tgt  = trap_vec & ALIGN_MASK;
        end else if (mret_en) begin
            new_prio = PRIO_MRET;
            new_tgt  = mepc & ALIGN_MASK;
        end else if (jump_en) begin
            new_prio = PRIO_JUMP;
            new_tgt  = jump_addr & ALIGN_MASK;
        end
    end

    assign pc_inc = curr_pc_q + PC_STEP;

    // In WAIT a new redirect replaces the pending one only at equal or
    // higher priority. The same rule applies on the granting edge, so a
    // trap arriving together with the grant is never lost.
    assign take_new = (new_prio != PRIO_NONE) &&
                      (!pend_valid_q || (new_prio >= pend_prio_q));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        curr_pc_d    = curr_pc_q;
        pc_ena_d     = pc_ena_q;
        flush_d      = 1'b0;
        epc_d        = epc_q;
        pend_valid_d = pend_valid_q;
        pend_prio_d  = pend_prio_q;
        pend_tgt_d   = pend_tgt_q;
        if_req       = 1'b0;
        next_pc      = curr_pc_q;

        case (state_q)
            ST_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d  = ST_RUN;
                    pc_ena_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if_req = !stall_i;
                if (new_prio != PRIO_NONE) begin
                    next_pc = new_tgt;
                end else if (stall_i) begin
                    next_pc = curr_pc_q;
                end else begin
                    next_pc = pc_inc;
                end

                // A redirect abandons any ungranted fetch and stays in RUN.
                if (new_prio != PRIO_NONE) begin
                    curr_pc_d = new_tgt;
                    flush_d   = 1'b1;
                    if (new_prio == PRIO_TRAP) begin
                        epc_d = curr_pc_q;
                    end
                end else if (if_req) begin
                    if (if_gnt) begin
                        curr_pc_d = next_pc;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if_req = 1'b1;
                if (take_new) begin
                    next_pc = new_tgt;
                end else if (pend_valid_q) begin
                    next_pc = pend_tgt_q;
                end else begin
                    next_pc = pc_inc;
                end

                if (take_new) begin
                    flush_d = 1'b1;
                    if (new_prio == PRIO_TRAP) begin
                        epc_d = curr_pc_q;
                    end
                end

                if (if_gnt) begin
                    curr_pc_d    = next_pc;
                    state_d      = ST_RUN;
                    pend_valid_d = 1'b0;
                    pend_prio_d  = PRIO_NONE;
                end else if (take_new) begin
                    pend_valid_d = 1'b1;
                    pend_prio_d  = new_prio;
                    pend_tgt_d   = new_tgt;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            cnt_q        <= '0;
            curr_pc_q    <= RESET_PC;
            pc_ena_q     <= 1'b0;
            flush_q      <= 1'b0;
            epc_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_prio_q  <= PRIO_NONE;
            pend_tgt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            curr_pc_q    <= curr_pc_d;
            pc_ena_q     <= pc_ena_d;
            flush_q      <= flush_d;
            epc_q        <= epc_d;
            pend_valid_q <= pend_valid_d;
            pend_prio_q  <= pend_prio_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    assign curr_pc = curr_pc_q;
    assign if_addr = curr_pc_q;
    assign pc_ena  = pc_ena_q;
    assign flush   = flush_q;
    assign epc_o   = epc_q;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        trap_en;
    logic [31:0] trap_vec;
    logic        mret_en;
    logic [31:0] mepc;
    logic        if_gnt;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] curr_pc;
    logic [31:0] next_pc;
    logic        pc_ena;
    logic        flush;
    logic [31:0] epc_o;

    pc_ctrl #(
        .CPU_WIDTH (32),
        .RESET_PC  (32'h0000_0000),
        .BOOT_DELAY(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stall_i),
        .jump_en  (jump_en),
        .jump_addr(jump_addr),
        .trap_en  (trap_en),
        .trap_vec (trap_vec),
        .mret_en  (mret_en),
        .mepc     (mepc),
        .if_gnt   (if_gnt),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .curr_pc  (curr_pc),
        .next_pc  (next_pc),
        .pc_ena   (pc_ena),
        .flush    (flush),
        .epc_o    (epc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle and the outputs expected during that same cycle.
    typedef struct {
        logic        stall;
        logic        jmp;
        logic [31:0] jaddr;
        logic        trap;
        logic [31:0] tvec;
        logic        mret;
        logic [31:0] mepc;
        logic        gnt;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_ena;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;
    int   cur_vec;

    function automatic vec_t mk(
        input logic stall, input logic jmp, input logic [31:0] jaddr,
        input logic trap, input logic [31:0] tvec,
        input logic mret, input logic [31:0] mepc_v, input logic gnt,
        input logic e_req, input logic [31:0] e_pc, input logic e_flush,
        input logic e_ena, input logic [31:0] e_epc);
        vec_t v;
        v.stall = stall; v.jmp = jmp; v.jaddr = jaddr;
        v.trap = trap; v.tvec = tvec; v.mret = mret; v.mepc = mepc_v;
        v.gnt = gnt; v.e_req = e_req; v.e_pc = e_pc; v.e_flush = e_flush;
        v.e_ena = e_ena; v.e_epc = e_epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, cur_vec, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall_i   = v.stall;
        jump_en   = v.jmp;
        jump_addr = v.jaddr;
        trap_en   = v.trap;
        trap_vec  = v.tvec;
        mret_en   = v.mret;
        mepc      = v.mepc;
        if_gnt    = v.gnt;
    endtask

    task automatic check_vec(input vec_t v);
        chk("if_req",  {31'd0, if_req}, {31'd0, v.e_req});
        chk("curr_pc", curr_pc, v.e_pc);
        chk("if_addr", if_addr, v.e_pc);
        chk("flush",   {31'd0, flush},  {31'd0, v.e_flush});
        chk("pc_ena",  {31'd0, pc_ena}, {31'd0, v.e_ena});
        chk("epc_o",   epc_o, v.e_epc);
    endtask

    localparam logic [31:0] Z = 32'h0;

    initial begin
        checks   = 0;
        failures = 0;
        cur_vec  = -1;
        //             stall jmp jaddr          trap tvec        mret mepc       gnt  req pc             fl ena epc
        // BOOT: redirects ignored
        vecs.push_back(mk(0, 1, 32'h80,        1, 32'h100,     0, Z,         1,   0, 32'h0,         0, 0, Z));          // 0
        vecs.push_back(mk(0, 0, Z,             0, Z,           1, 32'h28,    1,   0, 32'h0,         0, 0, Z));          // 1
        // RUN, sequential fetch
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h0,  0, 1, Z));                                          // 2
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h4,  0, 1, Z));                                          // 3
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h8,  0, 1, Z));                                          // 4
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'hC,  0, 1, Z));                                          // 5
        // grant low 3 cycles at 0x10 (stall ignored while waiting)
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 0,   1, 32'h10, 0, 1, Z));                                          // 6
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 0,   1, 32'h10, 0, 1, Z));                                          // 7
        vecs.push_back(mk(1, 0, Z, 0, Z, 0, Z, 0,   1, 32'h10, 0, 1, Z));                                          // 8
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h10, 0, 1, Z));                                          // 9
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h14, 0, 1, Z));                                          // 10
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h18, 0, 1, Z));                                          // 11
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h1C, 0, 1, Z));                                          // 12
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h20, 0, 1, Z));                                          // 13
        // trap + jump together at 0x24: trap wins
        vecs.push_back(mk(0, 1, 32'h80, 1, 32'h100, 0, Z, 1,   1, 32'h24,  0, 1, Z));                              // 14
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h100, 1, 1, 32'h24));                                    // 15
        vecs.push_back(mk(0, 0, Z, 0, Z, 1, 32'h28, 1,   1, 32'h104, 0, 1, 32'h24));                               // 16
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h28,  1, 1, 32'h24));                                    // 17
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h2C,  0, 1, 32'h24));                                    // 18
        // stall 4 cycles at 0x30
        vecs.push_back(mk(1, 0, Z, 0, Z, 0, Z, 1,   0, 32'h30,  0, 1, 32'h24));                                    // 19
        vecs.push_back(mk(1, 0, Z, 0, Z, 0, Z, 1,   0, 32'h30,  0, 1, 32'h24));                                    // 20
        vecs.push_back(mk(1, 0, Z, 0, Z, 0, Z, 1,   0, 32'h30,  0, 1, 32'h24));                                    // 21
        vecs.push_back(mk(1, 0, Z, 0, Z, 0, Z, 1,   0, 32'h30,  0, 1, 32'h24));                                    // 22
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h30,  0, 1, 32'h24));                                    // 23
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h34,  0, 1, 32'h24));                                    // 24
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h38,  0, 1, 32'h24));                                    // 25
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h3C,  0, 1, 32'h24));                                    // 26
        // jump to 0x203 while waiting at 0x40, granted two cycles later
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 0,   1, 32'h40,  0, 1, 32'h24));                                    // 27
        vecs.push_back(mk(0, 1, 32'h203, 0, Z, 0, Z, 0,   1, 32'h40, 0, 1, 32'h24));                               // 28
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 0,   1, 32'h40,  1, 1, 32'h24));                                    // 29
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h40,  0, 1, 32'h24));                                    // 30
        // jump in RUN with stall and no grant still redirects
        vecs.push_back(mk(1, 1, 32'h300, 0, Z, 0, Z, 0,   0, 32'h200, 0, 1, 32'h24));                              // 31
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h300, 1, 1, 32'h24));                                    // 32
        // back-to-back redirects give back-to-back flush
        vecs.push_back(mk(0, 1, 32'h400, 0, Z, 0, Z, 1,   1, 32'h304, 0, 1, 32'h24));                              // 33
        vecs.push_back(mk(0, 1, 32'h500, 0, Z, 0, Z, 1,   1, 32'h400, 1, 1, 32'h24));                              // 34
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h500, 1, 1, 32'h24));                                    // 35
        // pending trap in WAIT is not displaced by a later jump
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 0,   1, 32'h504, 0, 1, 32'h24));                                    // 36
        vecs.push_back(mk(0, 0, Z, 1, 32'h600, 0, Z, 0,   1, 32'h504, 0, 1, 32'h24));                              // 37
        vecs.push_back(mk(0, 1, 32'h700, 0, Z, 0, Z, 0,   1, 32'h504, 1, 1, 32'h504));                             // 38
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h504, 0, 1, 32'h504));                                   // 39
        // wrap from 0xFFFF_FFFC (target low bits forced to zero)
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 0, Z, 0, Z, 1,   1, 32'h600, 0, 1, 32'h504));                       // 40
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'hFFFF_FFFC, 1, 1, 32'h504));                             // 41
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 1,   1, 32'h0,   0, 1, 32'h504));                                   // 42
        // park in WAIT at 0xFFFF_FFFC for the reset sequence
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, Z, 0, Z, 1,   1, 32'h4, 0, 1, 32'h504));                         // 43
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 0,   1, 32'hFFFF_FFFC, 1, 1, 32'h504));                             // 44
        vecs.push_back(mk(0, 0, Z, 0, Z, 0, Z, 0,   1, 32'hFFFF_FFFC, 0, 1, 32'h504));                             // 45

        rst = 1'b1;
        drive(mk(0, 0, Z, 0, Z, 0, Z, 0, 0, Z, 0, 0, Z));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_req",  {31'd0, if_req}, 32'd0);
        chk("rst_curr_pc", curr_pc, 32'h0);
        chk("rst_pc_ena",  {31'd0, pc_ena}, 32'd0);
        chk("rst_flush",   {31'd0, flush},  32'd0);
        chk("rst_epc",     epc_o, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cur_vec = i;
            drive(vecs[i]);
            @(negedge clk);
            check_vec(vecs[i]);
            @(posedge clk);
            #1;
        end

        // Reset mid-handshake: effect must be immediate, not at the next edge.
        cur_vec = 100;
        chk("wait_pre_req", {31'd0, if_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wait_if_req",  {31'd0, if_req}, 32'd0);
        chk("rst_wait_curr_pc", curr_pc, 32'h0);
        chk("rst_wait_if_addr", if_addr, 32'h0);
        chk("rst_wait_pc_ena",  {31'd0, pc_ena}, 32'd0);
        chk("rst_wait_epc",     epc_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After release the old grant is not remembered: boot again, then
        // an ungranted request holds PC at the reset value.
        cur_vec = 101;
        if_gnt = 1'b0;
        @(posedge clk);
        #1;
        chk("reboot_boot_req", {31'd0, if_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("reboot_run_req", {31'd0, if_req}, 32'd1);
        chk("reboot_run_ena", {31'd0, pc_ena}, 32'd1);
        @(posedge clk);
        #1;
        chk("reboot_wait_pc",  curr_pc, 32'h0);
        chk("reboot_wait_req", {31'd0, if_req}, 32'd1);
        if_gnt = 1'b1;
        @(posedge clk);
        #1;
        chk("reboot_gnt_pc", curr_pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Sequences the program counter and instruction-fetch handshake for the core.
- Selects the next PC by priority: trap, mret, jump, stall, sequential +4.
- Holds the fetch request stable until it is granted, and emits a one-cycle flush on every accepted redirect.
- Sits between the execute/CSR stages (redirect sources) and instruction memory; replaces the free-running PC update.

Parameters:
- CPU_WIDTH, 32, width of PC and all address ports.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BOOT_DELAY, 2, cycles spent in BOOT after reset release before the first fetch (minimum effective value 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall_i  in  1  pipeline stall; hold PC and suppress new fetch.
- jump_en  in  1  branch/jump taken.
- jump_addr  in  CPU_WIDTH  branch/jump target.
- trap_en  in  1  exception/interrupt taken.
- trap_vec  in  CPU_WIDTH  trap handler address (mtvec).
- mret_en  in  1  return from trap.
- mepc  in  CPU_WIDTH  return address for mret.
- if_gnt  in  1  instruction memory accepts the request.
- if_req  out  1  fetch request.
- if_addr  out  CPU_WIDTH  fetch address; equals curr_pc.
- curr_pc  out  CPU_WIDTH  current PC (registered).
- next_pc  out  CPU_WIDTH  combinational PC selected for the next update.
- pc_ena  out  1  core enable; 1 once BOOT completes.
- flush  out  1  one-cycle pulse on an accepted redirect.
- epc_o  out  CPU_WIDTH  PC captured when a trap is accepted.

Behaviour:
- Reset (async, immediate):
  - state=BOOT, boot counter=0.
  - curr_pc=RESET_PC; if_req=0, pc_ena=0, flush=0, epc_o=0.
  - Pending-redirect valid=0.
  - Reset asserted mid-handshake drops if_req at once; no grant is remembered.
- BOOT state:
  - Counter increments each cycle. When it reaches max(BOOT_DELAY,1)-1, move to RUN and set pc_ena=1.
  - All redirects and stall are ignored; if_req=0.
- RUN state:
  - if_req = !stall_i.
  - If if_req && if_gnt: curr_pc <= next_pc; stay in RUN.
  - If if_req && !if_gnt: move to WAIT.
  - If stall_i=1 and no redirect: curr_pc is held.
- WAIT state:
  - if_req=1; if_addr/curr_pc are held stable until if_gnt; stall_i is ignored.
  - On if_gnt: curr_pc <= next_pc, then return to RUN.
- next_pc selection (first match wins):
  - pending redirect (WAIT only);
  - trap_en -> trap_vec;
  - mret_en -> mepc;
  - jump_en -> jump_addr;
  - stall_i -> curr_pc;
  - otherwise curr_pc+4.
- Redirects in RUN:
  - A trap, mret or jump takes effect at the next edge even when if_gnt=0 or stall_i=1.
  - The aborted fetch is dropped; if_req stays low for that cycle only if stall_i=1.
- Redirects in WAIT:
  - The target is latched into the pending register (valid=1) and applied at the granting edge; valid then clears.
  - A later redirect in the same WAIT overwrites the pending one only if its priority is equal or higher; trap always wins.
- flush:
  - Registered; equals 1 in the cycle after any redirect is accepted (RUN or latched in WAIT), else 0.
  - Redirects on consecutive cycles give flush high for consecutive cycles.
- epc_o <= curr_pc on the edge where trap_en is accepted; otherwise held.
- Arithmetic:
  - +4 wraps modulo 2^CPU_WIDTH; 32'hFFFF_FFFC goes to 32'h0000_0000.
  - Bits [1:0] of every redirect target are forced to 0 before use.
- if_addr is always identical to curr_pc.

Test Plan:
- Reset release, BOOT_DELAY=2, if_gnt tied 1 -> if_req first high 2 cycles after release, pc_ena=1 at the same time; curr_pc runs 0,4,8,C on consecutive cycles.
- if_gnt low for 3 cycles at pc=0x10 -> if_req=1 and if_addr=0x10 held for all 3 cycles; the next cycle after grant shows curr_pc=0x14.
- jump_en with jump_addr=0x203 during WAIT at pc=0x40, grant 2 cycles later -> curr_pc=0x200 after the grant; flush pulses once; no fetch of 0x44.
- trap_en (trap_vec=0x100) and jump_en (jump_addr=0x80) in the same cycle at pc=0x24 -> curr_pc=0x100, epc_o=0x24, flush=1 for 1 cycle; mret_en with mepc=0x28 later -> curr_pc=0x28.
- stall_i high 4 cycles at pc=0x30 -> if_req=0 and curr_pc=0x30 held; after release, sequence resumes at 0x34.
- Assert rst while in WAIT at pc=0xFFFF_FFFC -> if_req=0 immediately, curr_pc=0. Separate run: sequential from 0xFFFF_FFFC wraps to 0x0.
